// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word/state plus the memory arbiter's FSM state and grant owner.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IGNT  = 2'd1,
        DGNT  = 2'd2,
        RETRY = 2'd3
    } arbstate_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle between the instruction/data request ports, the arbiter and the single RAM port.
// Handshake: a requester holds xREN/xWEN (and its address/data) high until it sees its wait low;
// wait is low for exactly the one cycle the RAM reports ACCESS, and the load word is valid only then.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      memREN;
    logic      memWEN;
    word_t     memaddr;
    word_t     memstore;
    word_t     ramload;
    ramstate_t ramstate;

    // The arbiter side: takes requests, masters the RAM.
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, memREN, memWEN, memaddr, memstore
    );

    // The surroundings: requesters plus the RAM.
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, memREN, memWEN, memaddr, memstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one RAM port; holds each grant until ACCESS,
// reissues the latched transaction after a one-cycle RETRY when the RAM reports ERROR.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus,
    output arbstate_t     state_o
);

    arbstate_t state_q, state_d;
    owner_t    last_q, last_d;
    word_t     txn_addr_q, txn_addr_d;
    word_t     txn_store_q, txn_store_d;
    logic      txn_wen_q, txn_wen_d;

    owner_t    winner;
    logic      i_req, d_req;
    logic      granted, complete;

    assign i_req = bus.iREN;
    assign d_req = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            last_q      <= INSTR;
            txn_addr_q  <= '0;
            txn_store_q <= '0;
            txn_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            txn_addr_q  <= txn_addr_d;
            txn_store_q <= txn_store_d;
            txn_wen_q   <= txn_wen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        txn_addr_d  = txn_addr_q;
        txn_store_d = txn_store_q;
        txn_wen_d   = txn_wen_q;

        winner = DATA;
        if (i_req && !d_req) begin
            winner = INSTR;
        end else if (i_req && d_req && FAIR) begin
            winner = (last_q == INSTR) ? DATA : INSTR;
        end

        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    last_d = winner;
                    if (winner == DATA) begin
                        state_d     = DGNT;
                        txn_addr_d  = bus.daddr;
                        txn_store_d = bus.dstore;
                        txn_wen_d   = bus.dWEN;
                    end else begin
                        state_d     = IGNT;
                        txn_addr_d  = bus.iaddr;
                        txn_store_d = '0;
                        txn_wen_d   = 1'b0;
                    end
                end
            end
            IGNT, DGNT: begin
                if (bus.ramstate == ACCESS) begin
                    state_d = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    state_d = RETRY;
                end
            end
            // last_q still names the owner of the interrupted grant.
            RETRY: begin
                state_d = (last_q == DATA) ? DGNT : IGNT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        granted  = (state_q == IGNT) || (state_q == DGNT);
        complete = granted && (bus.ramstate == ACCESS);

        bus.memREN   = granted && !txn_wen_q;
        bus.memWEN   = granted && txn_wen_q;
        bus.memaddr  = txn_addr_q;
        bus.memstore = txn_store_q;

        bus.iwait = i_req;
        bus.dwait = d_req;
        bus.iload = '0;
        bus.dload = '0;

        // A dropped request still completes on the RAM; its wait is already low.
        if (complete && (state_q == IGNT)) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
        end
        if (complete && (state_q == DGNT)) begin
            bus.dwait = 1'b0;
            bus.dload = bus.ramload;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam bit    TB_FAIR = 1'b1;
    localparam word_t NF_KEY  = 32'hA5A5_0000;

    logic      CLK;
    logic      nRST;
    arbstate_t dut_state;
    arbstate_t nf_state;

    mem_arbiter_if bus ();
    mem_arbiter_if nf_bus ();

    mem_arbiter #(.FAIR(1'b1)) u_dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (bus.master),
        .state_o(dut_state)
    );

    mem_arbiter #(.FAIR(1'b0)) u_dut_nf (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (nf_bus.master),
        .state_o(nf_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM model with programmable latency and one-shot error injection
    word_t ram_mem [0:255];
    int    ram_cnt = 0;
    int    ram_lat;
    logic  err_inj;
    logic  ram_strobe;

    assign ram_strobe   = bus.memREN | bus.memWEN;
    assign bus.ramstate = err_inj ? ERROR :
                          (!ram_strobe ? FREE : ((ram_cnt == ram_lat) ? ACCESS : BUSY));
    assign bus.ramload  = (bus.ramstate == ACCESS) ? ram_mem[bus.memaddr[9:2]] : 32'h0;

    always @(posedge CLK) begin
        if (ram_strobe && (bus.ramstate == BUSY)) ram_cnt <= ram_cnt + 1;
        else ram_cnt <= 0;
    end

    assign nf_bus.ramstate = (nf_bus.memREN | nf_bus.memWEN) ? ACCESS : FREE;
    assign nf_bus.ramload  = (nf_bus.memREN | nf_bus.memWEN) ? (nf_bus.memaddr ^ NF_KEY) : 32'h0;

    // Stimulus variables, applied at the start of each cycle
    logic  s_nrst, s_iren, s_dren, s_dwen, s_err;
    word_t s_iaddr, s_daddr, s_dstore;
    int    s_lat;
    logic  nf_iren, nf_dren;
    word_t nf_iaddr, nf_daddr;

    // Reference model state
    word_t  sh_mem [0:255];
    logic   m_busy, m_retry, m_wen;
    owner_t m_owner, m_last;
    word_t  m_addr, m_store;
    word_t  last_iload, last_dload;

    int n_checks = 0;
    int n_err    = 0;

    function automatic word_t init_word(input int i);
        return (i == 16) ? 32'h8C01_0004 : (32'hC0DE_0000 + 32'(i));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic req_i, req_d;
        int   idx;
        req_i = bus.iREN;
        req_d = bus.dREN | bus.dWEN;
        if (!m_busy) begin
            chk("idle_memren", bus.memREN, 0);
            chk("idle_memwen", bus.memWEN, 0);
            chk("idle_iwait", bus.iwait, req_i);
            chk("idle_dwait", bus.dwait, req_d);
            chk("idle_iload", bus.iload, 0);
            chk("idle_dload", bus.dload, 0);
            if (req_i || req_d) begin
                if (req_i && req_d) m_owner = TB_FAIR ? ((m_last == INSTR) ? DATA : INSTR) : DATA;
                else m_owner = req_d ? DATA : INSTR;
                m_last  = m_owner;
                m_busy  = 1'b1;
                m_retry = 1'b0;
                if (m_owner == DATA) begin
                    m_addr  = bus.daddr;
                    m_store = bus.dstore;
                    m_wen   = bus.dWEN;
                end else begin
                    m_addr  = bus.iaddr;
                    m_store = '0;
                    m_wen   = 1'b0;
                end
            end
        end else if (m_retry) begin
            chk("retry_memren", bus.memREN, 0);
            chk("retry_memwen", bus.memWEN, 0);
            chk("retry_iwait", bus.iwait, req_i);
            chk("retry_dwait", bus.dwait, req_d);
            m_retry = 1'b0;
        end else begin
            chk("grant_memren", bus.memREN, !m_wen);
            chk("grant_memwen", bus.memWEN, m_wen);
            chk("grant_memaddr", bus.memaddr, m_addr);
            if (m_owner == DATA) chk("grant_memstore", bus.memstore, m_store);
            if (bus.ramstate == ACCESS) begin
                idx = int'(m_addr[9:2]);
                if (m_owner == INSTR) begin
                    chk("done_iwait", bus.iwait, 0);
                    chk("done_iload", bus.iload, sh_mem[idx]);
                    chk("done_other_dwait", bus.dwait, req_d);
                    chk("done_other_dload", bus.dload, 0);
                    last_iload = bus.iload;
                    s_iren     = 1'b0;
                end else begin
                    chk("done_dwait", bus.dwait, 0);
                    chk("done_dload", bus.dload, sh_mem[idx]);
                    chk("done_other_iwait", bus.iwait, req_i);
                    chk("done_other_iload", bus.iload, 0);
                    last_dload = bus.dload;
                    if (m_wen) sh_mem[idx] = m_store;
                    s_dren = 1'b0;
                    s_dwen = 1'b0;
                end
                m_busy = 1'b0;
            end else begin
                chk("busy_iwait", bus.iwait, req_i);
                chk("busy_dwait", bus.dwait, req_d);
                chk("busy_iload", bus.iload, 0);
                chk("busy_dload", bus.dload, 0);
                if (bus.ramstate == ERROR) m_retry = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        nRST          = s_nrst;
        bus.iREN      = s_iren;
        bus.iaddr     = s_iaddr;
        bus.dREN      = s_dren;
        bus.dWEN      = s_dwen;
        bus.daddr     = s_daddr;
        bus.dstore    = s_dstore;
        ram_lat       = s_lat;
        err_inj       = s_err;
        s_err         = 1'b0;
        nf_bus.iREN   = nf_iren;
        nf_bus.iaddr  = nf_iaddr;
        nf_bus.dREN   = nf_dren;
        nf_bus.dWEN   = 1'b0;
        nf_bus.daddr  = nf_daddr;
        nf_bus.dstore = '0;
        #1;
        if (nRST) model_step();
        if ((bus.ramstate == ACCESS) && bus.memWEN) ram_mem[bus.memaddr[9:2]] = bus.memstore;
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while ((m_busy || s_iren || s_dren || s_dwen) && (k < max)) begin
            cycle();
            k++;
        end
        chk("drain_timeout", (k < max), 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = init_word(i);
            sh_mem[i]  = init_word(i);
        end
        nRST = 1'b0; s_nrst = 1'b0;
        s_iren = 1'b0; s_dren = 1'b0; s_dwen = 1'b0; s_err = 1'b0;
        s_iaddr = '0; s_daddr = '0; s_dstore = '0; s_lat = 1;
        nf_iren = 1'b0; nf_dren = 1'b0; nf_iaddr = '0; nf_daddr = '0;
        bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0;
        nf_bus.iREN = 1'b0; nf_bus.iaddr = '0; nf_bus.dREN = 1'b0; nf_bus.dWEN = 1'b0;
        nf_bus.daddr = '0; nf_bus.dstore = '0;
        ram_lat = 1; err_inj = 1'b0;
        m_busy = 1'b0; m_retry = 1'b0; m_wen = 1'b0; m_owner = INSTR; m_last = INSTR;
        m_addr = '0; m_store = '0; last_iload = '0; last_dload = '0;

        // Outputs while held in reset
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_state", 32'(dut_state), 32'(IDLE));
        chk("reset_memren", bus.memREN, 0);
        chk("reset_memaddr", bus.memaddr, 0);
        chk("reset_memstore", bus.memstore, 0);
        bus.iREN = 1'b1;
        #1;
        chk("reset_iwait_follows", bus.iwait, 1);
        chk("reset_dwait_idle", bus.dwait, 0);
        bus.dWEN = 1'b1;
        #1;
        chk("reset_dwait_follows", bus.dwait, 1);
        chk("reset_memwen", bus.memWEN, 0);
        chk("reset_dload", bus.dload, 0);
        s_nrst = 1'b1;
        cycle();

        // Simultaneous requests right after reset: DATA first, INSTR two cycles after ACCESS
        s_lat = 1; s_iren = 1'b1; s_iaddr = 32'h40; s_dren = 1'b1; s_daddr = 32'h100;
        cycle();
        cycle();
        chk("sim_first_data", bus.memaddr, 32'h100);
        cycle();
        chk("sim_first_access_dwait", bus.dwait, 0);
        cycle();
        chk("sim_bubble_memren", bus.memREN, 0);
        cycle();
        chk("sim_second_instr", bus.memaddr, 32'h40);
        chk("sim_second_memren", bus.memREN, 1);
        drain(50);

        // Instruction-only fetch with RAM latency 3
        s_lat = 3; s_iren = 1'b1; s_iaddr = 32'h40;
        cycle();
        cycle();
        chk("ifetch_memren_c1", bus.memREN, 1);
        cycle();
        cycle();
        chk("ifetch_iwait_c3", bus.iwait, 1);
        cycle();
        chk("ifetch_iwait_c4", bus.iwait, 0);
        chk("ifetch_iload_c4", bus.iload, 32'h8C01_0004);
        cycle();
        chk("ifetch_idle_c5", 32'(dut_state), 32'(IDLE));
        drain(50);

        // Store, then read it back
        s_lat = 2; s_dwen = 1'b1; s_daddr = 32'h100; s_dstore = 32'hDEAD_BEEF;
        cycle();
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("store_memwen_held", bus.memWEN, 1);
        end
        drain(50);
        s_dren = 1'b1; s_daddr = 32'h100; s_dstore = '0;
        drain(50);
        chk("store_readback", last_dload, 32'hDEAD_BEEF);

        // ERROR during a data grant: one strobe-free cycle, then the same address again
        s_lat = 2; s_dren = 1'b1; s_daddr = 32'h80;
        cycle();
        s_err = 1'b1;
        cycle();
        chk("err_dwait", bus.dwait, 1);
        cycle();
        chk("err_retry_memren", bus.memREN, 0);
        chk("err_retry_dwait", bus.dwait, 1);
        cycle();
        chk("err_reissue_memren", bus.memREN, 1);
        chk("err_reissue_addr", bus.memaddr, 32'h80);
        drain(50);
        chk("err_load", last_dload, init_word(32));

        // FAIR=0 instance: DATA wins every time while it keeps requesting
        nf_iren = 1'b1; nf_iaddr = 32'h20; nf_dren = 1'b1; nf_daddr = 32'h30;
        for (int r = 0; r < 3; r++) begin
            cycle();
            chk("nf_arb_iwait", nf_bus.iwait, 1);
            chk("nf_arb_memren", nf_bus.memREN, 0);
            cycle();
            chk("nf_data_wins", nf_bus.dwait, 0);
            chk("nf_data_load", nf_bus.dload, (32'h30 + 32'(4 * r)) ^ NF_KEY);
            chk("nf_iwait_held", nf_bus.iwait, 1);
            nf_daddr = 32'h30 + 32'(4 * (r + 1));
        end
        nf_dren = 1'b0;
        cycle();
        chk("nf_instr_arb_iwait", nf_bus.iwait, 1);
        cycle();
        chk("nf_instr_done_iwait", nf_bus.iwait, 0);
        chk("nf_instr_done_iload", nf_bus.iload, 32'h20 ^ NF_KEY);
        nf_iren = 1'b0;
        cycle();

        // Asynchronous reset in the middle of an instruction grant
        s_lat = 4; s_iren = 1'b1; s_iaddr = 32'h44;
        cycle();
        cycle();
        chk("rst_pre_memren", bus.memREN, 1);
        nRST = 1'b0; s_nrst = 1'b0;
        #1;
        chk("rst_memren_drop", bus.memREN, 0);
        chk("rst_memaddr", bus.memaddr, 0);
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_iload", bus.iload, 0);
        chk("rst_state", 32'(dut_state), 32'(IDLE));
        m_busy = 1'b0; m_retry = 1'b0; m_last = INSTR;
        s_dren = 1'b1; s_daddr = 32'h48; s_nrst = 1'b1;
        cycle();
        cycle();
        chk("rst_regrant_data_first", bus.memaddr, 32'h48);
        drain(50);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            if (!s_iren && ($urandom_range(0, 2) == 0)) begin
                s_iren  = 1'b1;
                s_iaddr = word_t'($urandom_range(0, 127)) << 2;
            end
            if (!s_dren && !s_dwen && ($urandom_range(0, 2) == 0)) begin
                s_daddr = word_t'($urandom_range(0, 127)) << 2;
                if ($urandom_range(0, 1) == 1) begin
                    s_dwen   = 1'b1;
                    s_dstore = word_t'($urandom);
                end else begin
                    s_dren   = 1'b1;
                    s_dstore = '0;
                end
            end
            if (!m_busy) s_lat = $urandom_range(0, 4);
            if (m_busy && !m_retry && ($urandom_range(0, 15) == 0)) s_err = 1'b1;
            cycle();
        end
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter between the pipeline's instruction and data ports and the single `cpu_ram_if` RAM port. It serialises instruction fetches and data loads/stores onto the one RAM channel and holds each grant until RAM reports completion. Each requester gets a wait/load handshake. It sits directly upstream of the RAM. The system top's testbench mux (`tbCTRL`) stays downstream of it, unchanged.

## Interface
Parameters:
- FAIR, default 1: 1 = round-robin on simultaneous requests; 0 = data port always wins.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address (`word_t`).
- iwait  out  1  instruction request not yet complete.
- iload  out  32  fetched instruction.
- dREN  in  1  data read request.
- dWEN  in  1  data write request. dREN and dWEN are never both high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  data request not yet complete.
- dload  out  32  read data.
- memREN  out  1  RAM read strobe.
- memWEN  out  1  RAM write strobe.
- memaddr  out  32  RAM address.
- memstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states: IDLE, IGNT, DGNT, RETRY. State resets to IDLE.
- Registers and reset values:
  - last: last grant owner; resets to INSTR.
  - txn_addr, txn_store: reset to 0.
  - txn_wen: resets to 0.
- IDLE:
  - Sample requests. iReq = iREN. dReq = dREN | dWEN.
  - Only one request: grant it.
  - Both requests:
    - FAIR=1: grant the port not equal to `last`.
    - FAIR=0: grant DATA.
  - On grant:
    - latch addr, store and wen from the winning port.
    - go to IGNT or DGNT.
    - update `last`.
  - No request: stay in IDLE.
- IGNT/DGNT:
  - Drive memREN = !txn_wen and memWEN = txn_wen.
  - Drive memaddr = txn_addr and memstore = txn_store.
  - On ramstate == ACCESS: complete the transaction and go to IDLE.
  - On ramstate == ERROR: go to RETRY.
  - FREE/BUSY: hold the state.
- RETRY:
  - Strobes are 0 for exactly one cycle.
  - Then return to the grant state it came from. The transaction is reissued with the latched fields.
- Completion (combinational, in the ACCESS cycle only):
  - Granted port's wait = 0.
  - Its load = ramload.
  - The other port's wait = its request.
- Waits at all other times: iwait = iREN, dwait = dREN | dWEN.
- iload/dload when not completing: 0.
- Memory strobes in IDLE/RETRY: 0. memaddr/memstore always reflect the latched txn_* fields.
- A requester that drops its request mid-grant does not abort the RAM transaction. The arbiter completes it and discards the result. No wait pulse is produced because the request is low.

## Timing
- Request present at edge N (state IDLE) → grant state from N+1. Memory strobes are visible in cycle N+1.
- RAM with LAT=L gives ACCESS at cycle N+1+L. Wait is low only in that cycle. The arbiter is back in IDLE at N+2+L.
- Back-to-back requests: there is one IDLE bubble between transactions, which is the arbitration cycle.
- Store: memWEN stays high continuously from grant through the ACCESS cycle.
- Reset mid-transaction (asynchronous):
  - State goes to IDLE; strobes drop to 0 immediately.
  - txn_* and `last` return to their reset values.
  - Waits revert to the request levels.
- All outputs during reset: memREN = memWEN = 0, memaddr = memstore = 0, iload = dload = 0, iwait = iREN, dwait = dREN | dWEN.

## Structure
- `cpu_types_pkg` already holds `word_t` and `ramstate_t`.
- Add to it `arbstate_t` (IDLE, IGNT, DGNT, RETRY) and `owner_t` (INSTR, DATA).
- Single module with no sub-modules. The system top instantiates it between the caches' memory ports and `prif`.

## Test plan
- Instruction only: iREN=1, iaddr=0x40, RAM LAT=3, word 0x40=0x8C010004 → memREN=1 at cycle 1; iwait=0 and iload=0x8C010004 at cycle 4; IDLE at cycle 5.
- Store: dWEN=1, daddr=0x100, dstore=0xDEADBEEF → memWEN=1 through ACCESS. A later read of 0x100 returns 0xDEADBEEF.
- Simultaneous, FAIR=1, after reset: both requests at cycle 0 → DATA granted first (last = INSTR), INSTR second. The second grant starts two cycles after the first ACCESS.
- Simultaneous, FAIR=0, repeated three times → DATA wins every time. iwait stays high until DATA drops its request.
- ERROR injection: ramstate=ERROR for one cycle during DGNT → memREN=0 for one cycle, then reissued at the same address. dwait stays high until ACCESS.
- Reset mid-grant: nRST low during IGNT with memREN=1 → memREN=0 in the same cycle. After release, state is IDLE and the pending iREN is regranted with `last` = INSTR.
